// File: rtl/booth_r4_seq_mult_if.sv
// Operand/product handshake bundle for booth_r4_seq_mult.
// master = operand producer and product consumer, slave = the multiplier.
interface booth_r4_seq_mult_if #(
  parameter int unsigned WIDTH = 32
);
  logic               in_valid;
  logic               in_ready;
  logic               in_signed;
  logic [WIDTH-1:0]   in_a;
  logic [WIDTH-1:0]   in_b;
  logic               out_valid;
  logic               out_ready;
  logic [2*WIDTH-1:0] out_p;

  modport master (
    output in_valid, in_signed, in_a, in_b, out_ready,
    input  in_ready, out_valid, out_p
  );

  modport slave (
    input  in_valid, in_signed, in_a, in_b, out_ready,
    output in_ready, out_valid, out_p
  );
endinterface

// File: rtl/booth_r4_seq_mult.sv
// Multi-cycle radix-4 Booth multiplier retiring DIGITS_PER_CYCLE digits per clock,
// with valid/ready on operands and product; the product is held until accepted.
module booth_r4_seq_mult #(
  parameter int unsigned WIDTH            = 32,
  parameter int unsigned DIGITS_PER_CYCLE = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  booth_r4_seq_mult_if.slave   bus,
  output logic                 busy
);
  localparam int unsigned N_DIG    = WIDTH / 2 + 1;
  localparam int unsigned NUM_ITER = (N_DIG + DIGITS_PER_CYCLE - 1) / DIGITS_PER_CYCLE;
  localparam int unsigned PW       = 2 * WIDTH;
  localparam int unsigned BW       = 2 * NUM_ITER * DIGITS_PER_CYCLE + 1;
  localparam int unsigned STEP     = 2 * DIGITS_PER_CYCLE;
  localparam int unsigned CW       = (NUM_ITER > 1) ? $clog2(NUM_ITER) : 1;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_e;

  state_e          state_q, state_d;
  logic [PW-1:0]   a_q, a_d;
  logic [PW-1:0]   acc_q, acc_d;
  logic [PW-1:0]   p_q, p_d;
  logic [BW-1:0]   b_q, b_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            out_valid_q, out_valid_d;
  logic            busy_q, busy_d;

  logic            in_ready;
  logic            accept;
  logic            last_iter;
  logic [PW-1:0]   pp_sum;
  logic [PW-1:0]   pa;

  assign in_ready  = (state_q == IDLE) || ((state_q == DONE) && bus.out_ready);
  assign accept    = bus.in_valid && in_ready;
  assign last_iter = (cnt_q == CW'(NUM_ITER - 1));

  // The multiplicand and multiplier are shifted each iteration so the current
  // digit group always sits at bit 0; the overlap bit survives the shift.
  always_comb begin
    pp_sum = acc_q;
    pa     = '0;
    for (int unsigned j = 0; j < DIGITS_PER_CYCLE; j++) begin
      pa = a_q << (2 * j);
      case (b_q[2*j +: 3])
        3'b001, 3'b010: pp_sum = pp_sum + pa;
        3'b011:         pp_sum = pp_sum + (pa << 1);
        3'b100:         pp_sum = pp_sum - (pa << 1);
        3'b101, 3'b110: pp_sum = pp_sum - pa;
        default:        pp_sum = pp_sum;
      endcase
    end
  end

  always_comb begin
    state_d     = state_q;
    a_d         = a_q;
    b_d         = b_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    p_d         = p_q;
    out_valid_d = out_valid_q;
    busy_d      = busy_q;

    case (state_q)
      BUSY: begin
        acc_d = pp_sum;
        a_d   = a_q << STEP;
        b_d   = b_q >> STEP;
        cnt_d = cnt_q + CW'(1);
        if (last_iter) begin
          p_d         = pp_sum;
          out_valid_d = 1'b1;
          busy_d      = 1'b0;
          state_d     = DONE;
        end
      end
      DONE: begin
        if (bus.out_ready) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: ;
    endcase

    // Accept overrides DONE's return to IDLE so a consumed result can be
    // followed by new operands on the same edge.
    if (accept) begin
      a_d         = {{WIDTH{bus.in_signed & bus.in_a[WIDTH-1]}}, bus.in_a};
      b_d         = {{(BW-WIDTH-1){bus.in_signed & bus.in_b[WIDTH-1]}}, bus.in_b, 1'b0};
      acc_d       = '0;
      cnt_d       = '0;
      out_valid_d = 1'b0;
      busy_d      = 1'b1;
      state_d     = BUSY;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      a_q         <= '0;
      b_q         <= '0;
      acc_q       <= '0;
      cnt_q       <= '0;
      p_q         <= '0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      b_q         <= b_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      p_q         <= p_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid_q;
  assign bus.out_p     = p_q;
  assign busy          = busy_q;
endmodule

// File: doc/booth_r4_seq_mult.md
Name: booth_r4_seq_mult

Overview:
- Parametrised, multi-cycle radix-4 Booth multiplier with valid/ready handshakes on input and output.
- Successor to the 32-bit single-cycle combinational Booth multiplier. Generalises width, adds a per-operation signed/unsigned mode, and retires DIGITS_PER_CYCLE Booth digits per clock so that area can be traded for latency.
- Sits in the datapath in front of accumulate/MAC logic. Holds the result until the consumer accepts it.

Parameters:
- WIDTH, 32: operand width in bits. Must be even and >= 4.
- DIGITS_PER_CYCLE, 1: Booth digits (partial products) accumulated per clock. Range 1..WIDTH/2+1.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  operands presented.
- in_ready  out  1  block can accept operands.
- in_signed  in  1  1 = two's-complement operands; 0 = unsigned operands.
- in_a  in  WIDTH  multiplicand.
- in_b  in  WIDTH  multiplier.
- out_valid  out  1  product valid.
- out_ready  in  1  consumer accepts product.
- out_p  out  2*WIDTH  product.
- busy  out  1  high while state is BUSY.

Behaviour:
- Derived constants:
  - N_DIG = WIDTH/2+1.
  - NUM_ITER = ceil(N_DIG/DIGITS_PER_CYCLE).
  - Multiplier is extended to 2*NUM_ITER*DIGITS_PER_CYCLE+1 bits: LSB 0, then in_b, then in_b[WIDTH-1] when signed or 0 when unsigned. Padding digits beyond N_DIG decode to 000/111, so they contribute 0.
- Multiplicand is extended to 2*WIDTH bits, sign-extended when signed and zero-extended when unsigned.
- Booth digit decode from triple (b[2i+1], b[2i], b[2i-1]):
  - 000 and 111 give 0.
  - 001 and 010 give +A.
  - 011 gives +2A.
  - 100 gives -2A.
  - 101 and 110 give -A.
  - Each digit is shifted left 2i. All arithmetic is modulo 2^(2*WIDTH).
- Reset (async, rst_n=0):
  - state=IDLE.
  - in_ready=1, out_valid=0, busy=0.
  - out_p=0, accumulator=0, digit counter=0.
  - Takes effect immediately, including mid-operation. The in-flight operation is discarded and is never output.
- States:
  - IDLE: in_ready=1. On in_valid&in_ready: latch the extended operands and mode, clear the accumulator, counter=0, go to BUSY.
  - BUSY: in_ready=0. Each clock adds DIGITS_PER_CYCLE shifted partial products to the accumulator and increments the counter. On the clock that completes iteration NUM_ITER-1: out_p<=final sum, out_valid<=1, go to DONE.
  - DONE: out_valid=1 and out_p is held stable until out_valid&out_ready.
    - On handshake with in_valid=0: go to IDLE, out_valid<=0.
    - in_ready = out_ready while in DONE, so a back-to-back accept is allowed. If in_valid&out_ready: the result is consumed and the new operands are latched in the same edge, and the block goes straight to BUSY.
- Latency:
  - Operands accepted on edge k; out_valid rises after edge k+NUM_ITER.
  - Default configuration gives 17 cycles; DIGITS_PER_CYCLE=17 gives 1 cycle.
  - Back-to-back throughput is one result per NUM_ITER+1 cycles, minimum.
- Inputs are sampled only at the accept edge. Changes to in_a, in_b or in_signed afterwards have no effect.
- in_valid while BUSY is ignored (in_ready=0). There is no operand buffering.
- out_ready while not in DONE is ignored.
- out_p keeps its last value after the handshake until the next result is written. Only out_valid qualifies it.

Test Plan:
- Signed -1 x -1 (0xFFFFFFFF, 0xFFFFFFFF), out_ready=1 -> out_p=0x0000000000000001 exactly 17 cycles after accept, out_valid for 1 cycle.
- Unsigned 0xFFFFFFFF x 0xFFFFFFFF -> out_p=0xFFFFFFFE00000001.
- Signed 0x80000000 x 0x80000000 -> 0x4000000000000000; signed 0x80000000 x 0x7FFFFFFF -> 0xC000000080000000.
- Backpressure: hold out_ready=0 for 10 cycles after out_valid -> out_p and out_valid stable, in_ready=0. Then out_ready=1 with in_valid=1 and new operands 3 x 5 -> back-to-back accept, next out_p=15.
- Reset mid-operation: assert rst_n=0 at iteration 8 -> all outputs at reset values asynchronously. After release, no stale out_valid appears; the next 7 x -2 (signed) gives 0xFFFFFFFFFFFFFFF2.
- Parameter sweep: WIDTH in {4,8,16,32} x DIGITS_PER_CYCLE in {1,2,N_DIG}, 1000 random signed/unsigned operands each, checked against a reference product. Latency equals NUM_ITER for every case.
